// File: rtl/axis_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin AXI-Stream scheduler.
package axis_sched_pkg;

   localparam int TID_WIDTH = 2;
   localparam int MAX_PORTS = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } sched_state_e;

   // Round-robin successor of a port index, wrapping at num_ports.
   function automatic logic [TID_WIDTH-1:0] next_ptr(input logic [TID_WIDTH-1:0] idx,
                                                     input int num_ports);
      return (int'(idx) == num_ports - 1) ? '0 : idx + TID_WIDTH'(1);
   endfunction

endpackage

// File: rtl/axis_rr_scheduler_if.sv
// Bundle of requester-side and shared-datapath AXI-Stream signals.
// 'master' is the side that drives requesters and sinks the shared output; 'slave' is the scheduler.
interface axis_rr_scheduler_if #(
   parameter int NUM_PORTS         = 2,
   parameter int TDATA_WIDTH_BYTES = 4
);
   import axis_sched_pkg::*;

   logic [NUM_PORTS-1:0]                     s_axis_tvalid;
   logic [NUM_PORTS-1:0]                     s_axis_tready;
   logic [NUM_PORTS*TDATA_WIDTH_BYTES*8-1:0] s_axis_tdata;
   logic [NUM_PORTS-1:0]                     s_axis_tlast;
   logic                                     m_axis_tvalid;
   logic                                     m_axis_tready;
   logic [TDATA_WIDTH_BYTES*8-1:0]           m_axis_tdata;
   logic                                     m_axis_tlast;
   logic [TID_WIDTH-1:0]                     m_axis_tid;

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );

endinterface

// File: rtl/axis_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping to port 0.
module rr_pick
   import axis_sched_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [TID_WIDTH-1:0] ptr_i,
   output logic [NUM_PORTS-1:0] gnt_oh_o,
   output logic [TID_WIDTH-1:0] idx_o
);

   logic [NUM_PORTS-1:0]                masked;
   logic [NUM_PORTS-1:0]                first_masked;
   logic [NUM_PORTS-1:0]                first_any;
   logic [NUM_PORTS-1:0]                gnt_oh;
   logic [NUM_PORTS:0][TID_WIDTH-1:0]   idx_acc;

   assign idx_acc[0] = '0;

   // Requests at or above the pointer win; otherwise fall back to the lowest request overall.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign masked[gi] = req_i[gi] && (TID_WIDTH'(gi) >= ptr_i);
         if (gi == 0) begin : g_lsb
            assign first_masked[gi] = masked[gi];
            assign first_any[gi]    = req_i[gi];
         end else begin : g_upper
            assign first_masked[gi] = masked[gi] & ~(|masked[gi-1:0]);
            assign first_any[gi]    = req_i[gi]  & ~(|req_i[gi-1:0]);
         end
         assign idx_acc[gi+1] = idx_acc[gi] | (gnt_oh[gi] ? TID_WIDTH'(gi) : '0);
      end
   endgenerate

   assign gnt_oh   = (|masked) ? first_masked : first_any;
   assign gnt_oh_o = gnt_oh;
   assign idx_o    = idx_acc[NUM_PORTS];

endmodule

// File: rtl/axis_rr_scheduler.sv
// Packet-level round-robin scheduler: locks one requester per packet onto a registered output stage.
module axis_rr_scheduler
   import axis_sched_pkg::*;
#(
   parameter int TDATA_WIDTH_BYTES = 4,
   parameter int NUM_PORTS         = 2
) (
   input  logic               aclk,
   input  logic               reset,
   axis_rr_scheduler_if.slave bus
);

   localparam int DW = TDATA_WIDTH_BYTES * 8;

   generate
      if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
         $error("axis_rr_scheduler: NUM_PORTS out of range");
      end
   endgenerate

   sched_state_e         state_q, state_d;
   logic [TID_WIDTH-1:0] grant_q, grant_d;
   logic [TID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic                 m_tvalid_q, m_tvalid_d;
   logic [DW-1:0]        m_tdata_q, m_tdata_d;
   logic                 m_tlast_q, m_tlast_d;
   logic [TID_WIDTH-1:0] m_tid_q, m_tid_d;

   logic [NUM_PORTS-1:0]         pick_oh;
   logic [TID_WIDTH-1:0]         pick_idx;
   logic [NUM_PORTS-1:0]         grant_oh;
   logic [NUM_PORTS-1:0]         sel_oh;
   logic [TID_WIDTH-1:0]         sel_idx;
   logic [NUM_PORTS-1:0]         tready;
   logic [NUM_PORTS:0][DW-1:0]   data_acc;
   logic                         load;
   logic                         active;
   logic                         accept;
   logic                         sel_last;

   rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req_i    (bus.s_axis_tvalid),
      .ptr_i    (rr_ptr_q),
      .gnt_oh_o (pick_oh),
      .idx_o    (pick_idx)
   );

   assign data_acc[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign grant_oh[gi]   = (grant_q == TID_WIDTH'(gi));
         assign data_acc[gi+1] = data_acc[gi] | (sel_oh[gi] ? bus.s_axis_tdata[gi*DW +: DW] : '0);
      end
   endgenerate

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
         m_tid_q    <= m_tid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;

      load = !m_tvalid_q || bus.m_axis_tready;

      if (state_q == LOCKED) begin
         sel_oh  = grant_oh;
         sel_idx = grant_q;
         active  = 1'b1;
      end else begin
         sel_oh  = pick_oh;
         sel_idx = pick_idx;
         active  = |bus.s_axis_tvalid;
      end

      // Ready is gated by reset so an asserted reset silences every requester immediately.
      tready   = (active && load && !reset) ? sel_oh : '0;
      accept   = |(bus.s_axis_tvalid & tready);
      sel_last = |(bus.s_axis_tlast & sel_oh);

      if (load) begin
         m_tvalid_d = accept;
         if (accept) begin
            m_tdata_d = data_acc[NUM_PORTS];
            m_tlast_d = sel_last;
            m_tid_d   = sel_idx;
         end
      end

      // A tlast accepted straight out of IDLE never enters LOCKED.
      if (accept && sel_last) begin
         state_d  = IDLE;
         rr_ptr_d = next_ptr(sel_idx, NUM_PORTS);
      end else if (state_q == IDLE && active) begin
         state_d = LOCKED;
         grant_d = pick_idx;
      end
   end

   assign bus.s_axis_tready = tready;
   assign bus.m_axis_tvalid = m_tvalid_q;
   assign bus.m_axis_tdata  = m_tdata_q;
   assign bus.m_axis_tlast  = m_tlast_q;
   assign bus.m_axis_tid    = m_tid_q;

endmodule

// File: doc/axis_rr_scheduler.md
AXIS_RR_SCHEDULER -- requirements
Module: axis_rr_scheduler

Interface
REQ-001 Parameter TDATA_WIDTH_BYTES, default 4: byte width of every tdata bus.
REQ-002 Parameter NUM_PORTS, default 2, legal 2..4: number of AXI-Stream requesters sharing the downstream datapath.
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_axis_tvalid  input  NUM_PORTS  per-requester valid.
REQ-006 s_axis_tready  output  NUM_PORTS  per-requester ready.
REQ-007 s_axis_tdata  input  NUM_PORTS*TDATA_WIDTH_BYTES*8  packed per-requester data; port i occupies slice i.
REQ-008 s_axis_tlast  input  NUM_PORTS  per-requester end-of-packet.
REQ-009 m_axis_tvalid  output  1  shared-datapath valid.
REQ-010 m_axis_tready  input  1  shared-datapath ready.
REQ-011 m_axis_tdata  output  TDATA_WIDTH_BYTES*8  granted data.
REQ-012 m_axis_tlast  output  1  granted end-of-packet.
REQ-013 m_axis_tid  output  2  index of the source port of the current beat.

Function
REQ-014 FSM states: IDLE (no grant), LOCKED (grant held by one port).
REQ-015 IDLE: if any s_axis_tvalid is high, select a port round-robin starting at pointer rr_ptr, and move to LOCKED with grant = selected port in the same cycle the selection is made.
REQ-016 The selected port's first beat is accepted in the same cycle as the selection, provided the output register can load.
REQ-017 LOCKED: only s_axis_tready[grant] may be high; all other s_axis_tready bits are 0.
REQ-018 The output register can load when m_axis_tvalid==0 or m_axis_tready==1.
REQ-019 s_axis_tready[grant] = the output register's load condition (REQ-018).
REQ-020 Accepted beat latency: data, tlast and tid appear on the m_axis outputs exactly 1 cycle after the s_axis handshake.
REQ-021 Throughput: 1 beat/cycle sustained while the requester is valid and m_axis_tready stays high.
REQ-022 m_axis_tvalid, tdata, tlast and tid hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 When a beat with s_axis_tlast=1 is accepted, the FSM returns to IDLE and rr_ptr becomes (grant+1) mod NUM_PORTS.
REQ-024 Packets are never interleaved; the grant is released only on a tlast handshake.
REQ-025 If the granted port drops tvalid mid-packet, the grant is held indefinitely, with no timeout.
REQ-026 Single requester: that port is re-granted back-to-back, with no bubble between packets when its next valid is present in the IDLE cycle.
REQ-027 IDLE with all tvalid low: rr_ptr is unchanged and all s_axis_tready bits are 0.
REQ-028 A one-beat packet (tlast on the first beat) passes through LOCKED for 0 extra cycles; re-arbitration occurs the next cycle.
REQ-029 tid width is fixed at 2; unused upper values never occur.

Reset
REQ-030 Reset asserted asynchronously forces: state=IDLE, rr_ptr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, all s_axis_tready=0.
REQ-031 Reset mid-packet discards the in-flight beat and the lock; after release, arbitration restarts from port 0.
REQ-032 Outputs are driven from registers or from state only, so reset values appear without a clock edge.

Structure
REQ-033 Shared package axis_sched_pkg holds the state enum (IDLE, LOCKED), the TID_WIDTH=2 constant and the MAX_PORTS=4 constant.
REQ-034 One sub-module, rr_pick, is combinational: inputs are the request vector and the pointer; outputs are a one-hot grant and an index.
REQ-035 The downstream datapath is external; this block contains no data arithmetic.

Verification
REQ-036 Scenario 1, both ports continuously valid with 2-beat packets (A: 0x11,0x12; B: 0x21,0x22) and m_tready=1 -> output sequence 0x11,0x12,0x21,0x22,0x11..., with tid 0,0,1,1,0.
REQ-037 Scenario 2, port 1 only, three 1-beat packets 0xA0..0xA2 -> outputs on 3 consecutive cycles, tid=1 each, no gap.
REQ-038 Scenario 3, port 0 sends a 4-beat packet while port 1 is valid, with m_tready low on beat 2 for 3 cycles -> beat 2 is held stable for 3 cycles, port 1 sees tready=0 until port 0's tlast is accepted, then port 1 is granted.
REQ-039 Scenario 4, port 0 drops tvalid for 5 cycles mid-packet while port 1 is valid -> no port 1 beat appears until port 0 completes its tlast.
REQ-040 Scenario 5, reset pulsed during beat 2 of a 3-beat packet -> m_axis_tvalid=0 immediately, and the first post-reset grant goes to port 0 when both ports are valid.
REQ-041 Scenario 6, NUM_PORTS=4, all ports valid with 1-beat packets -> tid sequence 0,1,2,3,0.
